// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky-integrate-and-fire neuron array.
// Holds the reset-mode encoding, default sizing and the saturation helper.
package lif_pkg;

    localparam int W_DEF      = 8;
    localparam int REFRAC_DEF = 2;
    localparam int MAX_W      = 32;

    typedef enum logic {
        RST_ZERO = 1'b0,
        RST_SUB  = 1'b1
    } reset_mode_t;

    // Saturate an unsigned (w+1)-bit sum, carried in a MAX_W+1 container, to 2^w-1.
    function automatic logic [MAX_W-1:0] clamp_w(input logic [MAX_W:0] sum, input int unsigned w);
        logic [MAX_W:0] lim;
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One LIF neuron: leak, saturating integrate, threshold compare, refractory count.
// fire_o is the combinational spike decision for the current step.
module lif_cell
    import lif_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int REFRAC = REFRAC_DEF,
    parameter int LSW    = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           step_i,
    input  logic [W-1:0]   current_i,
    input  logic [W-1:0]   thresh_i,
    input  logic [LSW-1:0] leak_shift_i,
    input  reset_mode_t    reset_mode_i,
    output logic [W-1:0]   state_o,
    output logic           spike_o,
    output logic           fire_o
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [RW-1:0] refr;
    logic [W-1:0]  leaked;
    logic [W:0]    sum;
    logic [W-1:0]  clamped;
    logic [W-1:0]  state_next;
    logic          refractory;

    // Shift amounts >= W shift everything out, giving zero leak.
    assign leaked     = state_o - (state_o >> leak_shift_i);
    assign sum        = {1'b0, leaked} + {1'b0, current_i};
    assign clamped    = W'(clamp_w((MAX_W+1)'(sum), W));
    assign refractory = (refr != '0);
    assign fire_o     = !refractory && (clamped >= thresh_i);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = clamped;
        if (refractory)
            state_next = leaked;
        else if (fire_o)
            state_next = (reset_mode_i == RST_SUB) ? (clamped - thresh_i) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_o <= '0;
            spike_o <= 1'b0;
            refr    <= '0;
        end else if (step_i) begin
            state_o <= state_next;
            spike_o <= fire_o;
            if (refractory)
                refr <= refr - RW'(1);
            else if (fire_o)
                refr <= RW'(REFRAC);
        end else begin
            spike_o <= 1'b0;
        end
    end

endmodule

// File: rtl/lif_array.sv
// Array of N LIF neurons with an address-event spike output (valid/ready).
// Owns the pending-event vector, the lowest-index priority encoder and overflow.
module lif_array
    import lif_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = W_DEF,
    parameter int REFRAC = REFRAC_DEF,
    parameter int IDW    = (N > 1) ? $clog2(N) : 1,
    parameter int LSW    = $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic [N*W-1:0]   current_i,
    input  logic [W-1:0]     thresh_i,
    input  logic [LSW-1:0]   leak_shift_i,
    input  logic             reset_mode_i,
    output logic [N*W-1:0]   state_o,
    output logic [N-1:0]     spike_o,
    output logic             aer_valid_o,
    output logic [IDW-1:0]   aer_id_o,
    input  logic             aer_ready_i,
    output logic             overflow_o,
    input  logic             clear_ovf_i
);

    logic [N-1:0] fire;
    logic [N-1:0] new_spk;
    logic [N-1:0] pending;
    logic [N-1:0] ack_mask;
    logic [N-1:0] kept;

    for (genvar k = 0; k < N; k++) begin : g_cell
        lif_cell #(
            .W      (W),
            .REFRAC (REFRAC),
            .LSW    (LSW)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .step_i       (step_i),
            .current_i    (current_i[k*W +: W]),
            .thresh_i     (thresh_i),
            .leak_shift_i (leak_shift_i),
            .reset_mode_i (reset_mode_t'(reset_mode_i)),
            .state_o      (state_o[k*W +: W]),
            .spike_o      (spike_o[k]),
            .fire_o       (fire[k])
        );
    end

    assign aer_valid_o = |pending;
    assign new_spk     = step_i ? fire : '0;
    assign kept        = pending & ~ack_mask;

    // Scan high to low so the lowest pending index is the last assignment.
    always_comb begin
        aer_id_o = '0;
        for (int k = N - 1; k >= 0; k--)
            if (pending[k])
                aer_id_o = IDW'(k);
    end

    always_comb begin
        ack_mask = '0;
        if (aer_valid_o && aer_ready_i)
            ack_mask[aer_id_o] = 1'b1;
    end

    // A spike on a still-pending, unacknowledged neuron merges; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overflow_o <= 1'b0;
        end else begin
            pending <= kept | new_spk;
            if (|(new_spk & kept))
                overflow_o <= 1'b1;
            else if (clear_ovf_i)
                overflow_o <= 1'b0;
        end
    end

endmodule
